// File: rtl/rr_stream_mux_pkg.sv
// rr_stream_mux_pkg: shared constants and helpers for the N:1 stream mux.
//   MODE_FIXED / MODE_RR : values of the runtime arbitration mode input
//   wrap_inc()           : channel index increment with wrap to 0
package rr_stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Next channel index, wrapping from n-1 back to 0.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: fixed-priority / round-robin arbiter for rr_stream_mux.
//   clk, rst_n : clock, async active-low reset
//   req        : per-channel request (in_valid)
//   mode       : MODE_FIXED (lowest index wins) or MODE_RR
//   advance    : a beat is transferred on the granted channel this cycle
//   last       : per-channel end-of-packet (only with RR_STREAM_MUX_LAST_LOCK_EN)
//   grant      : one-hot grant, all-zero when no request
//   grant_idx  : binary index of the granted channel
// Owns the round-robin pointer and, with RR_STREAM_MUX_LAST_LOCK_EN defined,
// the packet lock that pins the grant to one channel until its last beat.
module rr_arbiter
  import rr_stream_mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              mode,
  input  logic              advance,
`ifdef RR_STREAM_MUX_LAST_LOCK_EN
  input  logic [NUM_CH-1:0] last,
`endif
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx
);

  logic [CH_W-1:0] r_last_grant;
  logic            w_found;
  int unsigned     w_idx;

`ifdef RR_STREAM_MUX_LAST_LOCK_EN
  logic            r_locked;
  logic [CH_W-1:0] r_lock_ch;
`endif

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_idx     = 0;
    if (mode == MODE_RR) begin
      // Search starts one past the last winner and wraps.
      w_idx = 32'(r_last_grant);
      for (int k = 0; k < NUM_CH; k++) begin
        w_idx = wrap_inc(w_idx, NUM_CH);
        if (!w_found && req[CH_W'(w_idx)]) begin
          w_found   = 1'b1;
          grant_idx = CH_W'(w_idx);
        end
      end
    end else begin
      // Descending scan so the lowest valid index is written last.
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        if (req[k]) begin
          w_found   = 1'b1;
          grant_idx = CH_W'(k);
        end
      end
    end
`ifdef RR_STREAM_MUX_LAST_LOCK_EN
    // Mid-packet: only the locked channel may proceed, regardless of mode.
    if (r_locked) begin
      w_found   = req[r_lock_ch];
      grant_idx = r_lock_ch;
    end
`endif
    if (w_found) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= CH_W'(NUM_CH - 1);
`ifdef RR_STREAM_MUX_LAST_LOCK_EN
      r_locked     <= 1'b0;
      r_lock_ch    <= '0;
`endif
    end else if (advance) begin
      if (mode == MODE_RR) r_last_grant <= grant_idx;
`ifdef RR_STREAM_MUX_LAST_LOCK_EN
      r_locked  <= !last[grant_idx];
      r_lock_ch <= grant_idx;
`endif
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N:1 valid/ready stream multiplexer with a registered output.
//   clk, rst_n       : clock, async active-low reset
//   mode             : 0 = fixed priority (lowest index), 1 = round-robin
//   in_valid/in_data : NUM_CH input streams, channel i at in_data[i*DATA_W +: DATA_W]
//   in_ready         : per-channel ready, at most one set
//   out_valid/out_data/out_ch : registered output beat and its source channel
//   out_ready        : consumer ready
// Optional macro RR_STREAM_MUX_LAST_LOCK_EN adds in_last/out_last and keeps
// a channel granted from its first beat until the beat carrying in_last.
module rr_stream_mux
  import rr_stream_mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = 8,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
`ifdef RR_STREAM_MUX_LAST_LOCK_EN
  input  logic [NUM_CH-1:0]        in_last,
`endif
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
`ifdef RR_STREAM_MUX_LAST_LOCK_EN
  output logic                     out_last,
`endif
  input  logic                     out_ready
);

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [CH_W-1:0]   r_out_ch;
  logic              w_load_en;
  logic              w_advance;
  logic [NUM_CH-1:0] w_grant;
  logic [CH_W-1:0]   w_grant_idx;

  // Output register can take a beat when empty or draining this cycle.
  assign w_load_en = !r_out_valid || out_ready;
  assign w_advance = (|w_grant) && w_load_en;
  assign in_ready  = w_grant & {NUM_CH{w_load_en}};

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (in_valid),
    .mode      (mode),
    .advance   (w_advance),
`ifdef RR_STREAM_MUX_LAST_LOCK_EN
    .last      (in_last),
`endif
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

`ifdef RR_STREAM_MUX_LAST_LOCK_EN
  logic r_out_last;
  assign out_last = r_out_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_out_last <= 1'b0;
    else if (w_advance) r_out_last <= in_last[w_grant_idx];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
    end else if (w_load_en) begin
      // With no grant the register empties; data/ch keep their last values.
      r_out_valid <= |w_grant;
      if (|w_grant) begin
        r_out_data <= in_data[w_grant_idx*DATA_W +: DATA_W];
        r_out_ch   <= w_grant_idx;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_rr_stream_mux.sv
module tb_rr_stream_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_ready;
`ifdef RR_STREAM_MUX_LAST_LOCK_EN
  logic [3:0]  in_last;
  logic        out_last;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int       m_last;
  bit       m_ov;
  bit [7:0] m_od;
  int       m_och;
`ifdef RR_STREAM_MUX_LAST_LOCK_EN
  bit       m_locked;
  int       m_lock_ch;
  bit       m_olast;
`endif

  always #5 clk = ~clk;

  rr_stream_mux #(.NUM_CH(4), .DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef RR_STREAM_MUX_LAST_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
`ifdef RR_STREAM_MUX_LAST_LOCK_EN
    .out_last  (out_last),
`endif
    .out_ready (out_ready)
  );

  function automatic void model_reset();
    m_last = 3; m_ov = 0; m_od = 8'h00; m_och = 0;
`ifdef RR_STREAM_MUX_LAST_LOCK_EN
    m_locked = 0; m_lock_ch = 0; m_olast = 0;
`endif
  endfunction

  // Which channel the rules say wins right now (-1 = none).
  function automatic int exp_grant();
`ifdef RR_STREAM_MUX_LAST_LOCK_EN
    if (m_locked) return in_valid[m_lock_ch] ? m_lock_ch : -1;
`endif
    if (mode == 1'b0) begin
      for (int i = 0; i < 4; i++) if (in_valid[i]) return i;
    end else begin
      for (int k = 1; k <= 4; k++) if (in_valid[(m_last + k) % 4]) return (m_last + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    logic [3:0] r;
    int g;
    r = 4'b0000;
    g = exp_grant();
    if (g >= 0 && (!m_ov || out_ready)) r[g] = 1'b1;
    return r;
  endfunction

  // Advance one clock and the model alongside it (no checking here).
  task automatic tick();
    int g;
    bit le;
    g  = exp_grant();
    le = !m_ov || out_ready;
    @(posedge clk);
    if (le) begin
      m_ov = (g >= 0);
      if (g >= 0) begin
        m_od  = in_data[g*8 +: 8];
        m_och = g;
        if (mode) m_last = g;
`ifdef RR_STREAM_MUX_LAST_LOCK_EN
        m_olast   = in_last[g];
        m_locked  = !in_last[g];
        m_lock_ch = g;
`endif
      end
    end
    #1;
  endtask

  task automatic do_reset();
    in_valid = 4'b0000;
    rst_n = 1'b0;
    model_reset();
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b0; in_valid = 4'b0000; in_data = 32'h0; out_ready = 1'b1;
`ifdef RR_STREAM_MUX_LAST_LOCK_EN
    in_last = 4'b0000;
`endif
    model_reset();
    #12;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_tests++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", out_data); end
    n_tests++; if (out_ch !== 2'd0) begin n_fail++; $display("FAIL reset_ch got %0d want 0", out_ch); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL idle_ready got %b want 0000", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid got %b want 0", out_valid); end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    mode = 1'b0; out_ready = 1'b1;
    in_data = {8'h33, 8'hCC, 8'h11, 8'hDD};
    in_valid = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL fixed_ready got %b want 0010", in_ready); end
      tick();
      n_tests++; if (out_valid !== 1'b1 || out_data !== 8'h11 || out_ch !== 2'd1) begin
        n_fail++; $display("FAIL fixed_out got v%b d%h c%0d want v1 d11 c1", out_valid, out_data, out_ch);
      end
    end
  endtask

  task automatic test_rr_all();
    int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    mode = 1'b1; out_ready = 1'b1;
    in_data = {8'h43, 8'h42, 8'h41, 8'h40};
    in_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_tests++; if (out_valid !== 1'b1 || out_ch !== 2'(exp_seq[i]) || out_data !== 8'(8'h40 + exp_seq[i])) begin
        n_fail++; $display("FAIL rr_seq[%0d] got v%b c%0d d%h want v1 c%0d", i, out_valid, out_ch, out_data, exp_seq[i]);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    mode = 1'b1; out_ready = 1'b1;
    in_data = {8'h04, 8'h03, 8'h02, 8'hA5};
    in_valid = 4'b1111;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_ready got %b want 0000", in_ready); end
      tick();
      n_tests++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd0) begin
        n_fail++; $display("FAIL stall_hold got v%b d%h c%0d want v1 dA5 c0", out_valid, out_data, out_ch);
      end
    end
    out_ready = 1'b1;
    #1;
    n_tests++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL release_ready got %b want 0010", in_ready); end
    tick();
    n_tests++; if (out_ch !== 2'd1 || out_data !== 8'h02) begin
      n_fail++; $display("FAIL release_out got c%0d d%h want c1 d02", out_ch, out_data);
    end
  endtask

  task automatic test_wrap();
    int exp_seq[3] = '{0, 3, 0};
    do_reset();
    mode = 1'b1; out_ready = 1'b1;
    in_data = {8'h99, 8'h00, 8'h00, 8'h66};
    in_valid = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (out_ch !== 2'(exp_seq[i])) begin
        n_fail++; $display("FAIL wrap[%0d] got c%0d want c%0d", i, out_ch, exp_seq[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    mode = 1'b1; out_ready = 1'b1;
    in_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    in_valid = 4'b1111;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid got %b want 0", out_valid); end
    model_reset();
    #3 rst_n = 1'b1;
    tick();
    n_tests++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'hD0) begin
      n_fail++; $display("FAIL midreset_first got v%b c%0d d%h want v1 c0 dD0", out_valid, out_ch, out_data);
    end
  endtask

`ifdef RR_STREAM_MUX_LAST_LOCK_EN
  task automatic test_lock();
    do_reset();
    mode = 1'b1; out_ready = 1'b1;
    in_last = 4'b0000;
    in_data = {8'h00, 8'hC0, 8'hB0, 8'hA0};
    in_valid = 4'b0100;
    tick();
    n_tests++; if (out_ch !== 2'd2 || out_last !== 1'b0) begin n_fail++; $display("FAIL lock_b0 got c%0d l%b want c2 l0", out_ch, out_last); end
    in_valid = 4'b0111; mode = 1'b0; in_data[23:16] = 8'hC1;
    #1;
    n_tests++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL lock_ready got %b want 0100", in_ready); end
    tick();
    n_tests++; if (out_ch !== 2'd2 || out_data !== 8'hC1) begin n_fail++; $display("FAIL lock_b1 got c%0d d%h want c2 dC1", out_ch, out_data); end
    mode = 1'b1; in_last = 4'b0100; in_data[23:16] = 8'hC2;
    tick();
    n_tests++; if (out_ch !== 2'd2 || out_last !== 1'b1) begin n_fail++; $display("FAIL lock_b2 got c%0d l%b want c2 l1", out_ch, out_last); end
    in_valid = 4'b0011; in_last = 4'b0000;
    tick();
    n_tests++; if (out_ch !== 2'd0) begin n_fail++; $display("FAIL lock_resume got c%0d want c0", out_ch); end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      mode      = 1'($urandom);
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef RR_STREAM_MUX_LAST_LOCK_EN
      in_last   = 4'($urandom);
`endif
      #1;
      n_tests++; if (in_ready !== exp_ready()) begin
        n_fail++; $display("FAIL rand_ready[%0d] got %b want %b", i, in_ready, exp_ready());
      end
      tick();
      n_tests++; if (out_valid !== m_ov || out_data !== m_od || out_ch !== 2'(m_och)) begin
        n_fail++; $display("FAIL rand_out[%0d] got v%b d%h c%0d want v%b d%h c%0d", i, out_valid, out_data, out_ch, m_ov, m_od, m_och);
      end
`ifdef RR_STREAM_MUX_LAST_LOCK_EN
      n_tests++; if (out_last !== m_olast) begin
        n_fail++; $display("FAIL rand_last[%0d] got %b want %b", i, out_last, m_olast);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_rr_all();
    test_stall();
    test_wrap();
    test_reset_midstream();
`ifdef RR_STREAM_MUX_LAST_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
